// File: rtl/wb_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : wb_port_arbiter
// Brief    : Shares the register-file write port between the in-order pipeline
//            (fixed priority) and N_AUX multicycle units (round-robin).
//            Optional macro STARVE_GUARD_EN lets a starving aux pre-empt the pipe.
// Revision : 1.0  initial release
// =============================================================================
module wb_port_arbiter #(
    parameter int N_AUX    = 2,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pipe_regwrite,
    input  logic [4:0]             pipe_rd,
    input  logic [31:0]            pipe_data,
    output logic                   pipe_stall,
    input  logic [N_AUX-1:0]       aux_valid,
    input  logic [5*N_AUX-1:0]     aux_rd,
    input  logic [32*N_AUX-1:0]    aux_data,
    output logic [N_AUX-1:0]       aux_ready,
    output logic                   wb_regwrite,
    output logic [4:0]             wb_rd,
    output logic [31:0]            wb_write_data,
    output logic [31:0]            aux_pending_mask,
    output logic [CNT_W-1:0]       conflict_cnt
);

    localparam int               PTR_W     = (N_AUX > 1) ? $clog2(N_AUX) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [PTR_W-1:0] C_PTR_TOP = PTR_W'(N_AUX - 1);

    generate
        if (N_AUX < 1 || N_AUX > 4 || MAX_WAIT < 1) begin : g_param_check
            $error("wb_port_arbiter: N_AUX must be 1..4 and MAX_WAIT >= 1");
        end
    endgenerate

    logic [PTR_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0]  r_conflict_cnt;
    logic              r_wb_regwrite;
    logic [4:0]        r_wb_rd;
    logic [31:0]       r_wb_data;

    logic              w_pipe_active;
    logic              w_rr_found;
    logic [PTR_W-1:0]  w_rr_idx;
    logic [PTR_W:0]    w_rr_dist;
    logic [PTR_W:0]    w_rr_best;
    logic              w_starve_any;
    logic [PTR_W-1:0]  w_starve_idx;
    logic              w_grant;
    logic [PTR_W-1:0]  w_grant_idx;
    logic              w_stall;
    logic [4:0]        w_grant_rd;
    logic [31:0]       w_grant_data;
    logic [PTR_W-1:0]  w_ptr_next;

    // A pipe write to x0 never occupies the port.
    assign w_pipe_active = pipe_regwrite && (pipe_rd != 5'd0);

    // Round-robin pick: the valid unit closest to the pointer, counting upward with wrap.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_rr_dist  = '0;
        w_rr_best  = '0;
        for (int i = 0; i < N_AUX; i++) begin
            if (PTR_W'(i) >= r_rr_ptr) begin
                w_rr_dist = (PTR_W+1)'(i) - {1'b0, r_rr_ptr};
            end else begin
                w_rr_dist = (PTR_W+1)'(i) + (PTR_W+1)'(N_AUX) - {1'b0, r_rr_ptr};
            end
            if (aux_valid[i] && (!w_rr_found || (w_rr_dist < w_rr_best))) begin
                w_rr_found = 1'b1;
                w_rr_best  = w_rr_dist;
                w_rr_idx   = PTR_W'(i);
            end
        end
    end

`ifdef STARVE_GUARD_EN
    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] C_WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait [N_AUX];

    always_comb begin
        w_starve_any = 1'b0;
        w_starve_idx = '0;
        for (int i = N_AUX - 1; i >= 0; i--) begin
            if (aux_valid[i] && (r_wait[i] == C_WAIT_MAX)) begin
                w_starve_any = 1'b1;
                w_starve_idx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_AUX; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_AUX; i++) begin
                if (!aux_valid[i] || aux_ready[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != C_WAIT_MAX) begin
                    r_wait[i] <= r_wait[i] + WAIT_W'(1);
                end
            end
        end
    end
`else
    assign w_starve_any = 1'b0;
    assign w_starve_idx = '0;
`endif

    // Ownership: starving aux > active pipe > round-robin aux. Nothing is granted under reset.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_stall     = 1'b0;
        if (!reset) begin
            if (w_starve_any) begin
                w_grant     = 1'b1;
                w_grant_idx = w_starve_idx;
                w_stall     = w_pipe_active;
            end else if (!w_pipe_active && w_rr_found) begin
                w_grant     = 1'b1;
                w_grant_idx = w_rr_idx;
            end
        end
    end

    always_comb begin
        aux_ready    = '0;
        w_grant_rd   = '0;
        w_grant_data = '0;
        for (int i = 0; i < N_AUX; i++) begin
            if (w_grant_idx == PTR_W'(i)) begin
                aux_ready[i] = w_grant;
                w_grant_rd   = aux_rd[5*i +: 5];
                w_grant_data = aux_data[32*i +: 32];
            end
        end
    end

    assign w_ptr_next = (w_grant_idx == C_PTR_TOP) ? '0 : w_grant_idx + PTR_W'(1);
    assign pipe_stall = w_stall;

    always_comb begin
        aux_pending_mask = '0;
        for (int i = 0; i < N_AUX; i++) begin
            if (aux_valid[i] && !reset) begin
                aux_pending_mask[aux_rd[5*i +: 5]] = 1'b1;
            end
        end
        aux_pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr       <= '0;
            r_conflict_cnt <= '0;
            r_wb_regwrite  <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
        end else begin
            if (w_grant) begin
                // An aux write to x0 is consumed but never reaches the register file.
                r_rr_ptr      <= w_ptr_next;
                r_wb_regwrite <= (w_grant_rd != 5'd0);
                r_wb_rd       <= w_grant_rd;
                r_wb_data     <= w_grant_data;
            end else if (w_pipe_active) begin
                r_wb_regwrite <= 1'b1;
                r_wb_rd       <= pipe_rd;
                r_wb_data     <= pipe_data;
            end else begin
                r_wb_regwrite <= 1'b0;
            end

            if ((aux_valid != '0) && !w_grant && (r_conflict_cnt != C_CNT_MAX)) begin
                r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
            end
        end
    end

    assign wb_regwrite   = r_wb_regwrite;
    assign wb_rd         = r_wb_rd;
    assign wb_write_data = r_wb_data;
    assign conflict_cnt  = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_wb_port_arbiter
// Brief    : Directed and random stimulus for wb_port_arbiter, checked against
//            a cycle-level ownership model. Honours STARVE_GUARD_EN if defined.
// Revision : 1.0  initial release
// =============================================================================
module tb_wb_port_arbiter;

    localparam int N_AUX    = 2;
    localparam int MAX_WAIT = 8;
    localparam int CNT_W    = 16;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic                   clk;
    logic                   reset;
    logic                   pipe_regwrite;
    logic [4:0]             pipe_rd;
    logic [31:0]            pipe_data;
    logic                   pipe_stall;
    logic [N_AUX-1:0]       aux_valid;
    logic [5*N_AUX-1:0]     aux_rd;
    logic [32*N_AUX-1:0]    aux_data;
    logic [N_AUX-1:0]       aux_ready;
    logic                   wb_regwrite;
    logic [4:0]             wb_rd;
    logic [31:0]            wb_write_data;
    logic [31:0]            aux_pending_mask;
    logic [CNT_W-1:0]       conflict_cnt;

    wb_port_arbiter #(
        .N_AUX    (N_AUX),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .pipe_regwrite    (pipe_regwrite),
        .pipe_rd          (pipe_rd),
        .pipe_data        (pipe_data),
        .pipe_stall       (pipe_stall),
        .aux_valid        (aux_valid),
        .aux_rd           (aux_rd),
        .aux_data         (aux_data),
        .aux_ready        (aux_ready),
        .wb_regwrite      (wb_regwrite),
        .wb_rd            (wb_rd),
        .wb_write_data    (wb_write_data),
        .aux_pending_mask (aux_pending_mask),
        .conflict_cnt     (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Requester-side view of each aux unit.
    bit          av   [N_AUX];
    logic [4:0]  ard  [N_AUX];
    logic [31:0] adat [N_AUX];

    // Reference state: what the write port must have done so far.
    int          m_ptr;
    int          m_wait [N_AUX];
    int          m_cnt;
    bit          m_wr;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          g_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_cnt  = 0;
        m_wr   = 1'b0;
        m_rd   = '0;
        m_data = '0;
        for (int i = 0; i < N_AUX; i++) m_wait[i] = 0;
    endtask

    task automatic pack();
        for (int i = 0; i < N_AUX; i++) begin
            aux_valid[i]         = av[i];
            aux_rd[5*i +: 5]     = ard[i];
            aux_data[32*i +: 32] = adat[i];
        end
    endtask

    task automatic new_req(input int i);
        av[i]   = ($urandom_range(0, 2) != 0);
        ard[i]  = 5'($urandom_range(0, 31));
        adat[i] = $urandom;
    endtask

    // One clock: check grant outputs before the edge, then registered outputs after it.
    task automatic cycle();
        int          g;
        bit          st;
        bit          pact;
        bit          any_v;
        logic [31:0] msk;
        logic [31:0] rdy;
        pack();
        #1;
        pact  = pipe_regwrite && (pipe_rd != 5'd0);
        g     = -1;
        st    = 1'b0;
        any_v = 1'b0;
`ifdef STARVE_GUARD_EN
        for (int i = N_AUX - 1; i >= 0; i--)
            if (av[i] && m_wait[i] >= MAX_WAIT) g = i;
        if (g >= 0) st = pact;
`endif
        if (g < 0 && !pact)
            for (int k = 0; k < N_AUX; k++)
                if (g < 0 && av[(m_ptr + k) % N_AUX]) g = (m_ptr + k) % N_AUX;
        rdy = '0;
        if (g >= 0) rdy[g] = 1'b1;
        msk = '0;
        for (int i = 0; i < N_AUX; i++) begin
            any_v = any_v | av[i];
            if (av[i]) msk[ard[i]] = 1'b1;
        end
        msk[0] = 1'b0;
        chk("aux_ready", 32'(aux_ready), rdy);
        chk("pipe_stall", 32'(pipe_stall), 32'(st));
        chk("pending_mask", aux_pending_mask, msk);

        @(posedge clk);
        if (g >= 0) begin
            m_wr   = (ard[g] != 5'd0);
            m_rd   = ard[g];
            m_data = adat[g];
            m_ptr  = (g + 1) % N_AUX;
        end else if (pact) begin
            m_wr   = 1'b1;
            m_rd   = pipe_rd;
            m_data = pipe_data;
        end else begin
            m_wr = 1'b0;
        end
        if (any_v && g < 0 && m_cnt < CMAX) m_cnt++;
        for (int i = 0; i < N_AUX; i++) begin
            if (!av[i] || g == i) m_wait[i] = 0;
            else if (m_wait[i] < MAX_WAIT) m_wait[i]++;
        end
        #1;
        chk("wb_regwrite", 32'(wb_regwrite), 32'(m_wr));
        chk("wb_rd", 32'(wb_rd), 32'(m_rd));
        chk("wb_write_data", wb_write_data, m_data);
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
        g_last = g;
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] exp_rd;

        reset         = 1'b1;
        pipe_regwrite = 1'b0;
        pipe_rd       = '0;
        pipe_data     = '0;
        for (int i = 0; i < N_AUX; i++) begin
            av[i]   = 1'b0;
            ard[i]  = '0;
            adat[i] = '0;
        end
        pack();
        model_reset();
        g_last = -1;
        repeat (2) @(negedge clk);
        chk("reset wb_regwrite", 32'(wb_regwrite), 32'd0);
        chk("reset wb_rd", 32'(wb_rd), 32'd0);
        chk("reset wb_write_data", wb_write_data, 32'd0);
        chk("reset conflict_cnt", 32'(conflict_cnt), 32'd0);
        chk("reset aux_ready", 32'(aux_ready), 32'd0);
        chk("reset pipe_stall", 32'(pipe_stall), 32'd0);
        reset = 1'b0;

        // T3: two aux units alternate while the pipe is idle.
        av[0] = 1'b1; ard[0] = 5'd4; adat[0] = 32'h0000_0A04;
        av[1] = 1'b1; ard[1] = 5'd6; adat[1] = 32'h0000_0B06;
        for (int t = 0; t < 4; t++) begin
            pack();
            #1;
            chk("T3 grant order", 32'(aux_ready), (t % 2 == 0) ? 32'd1 : 32'd2);
            exp_rd = ard[t % 2];
            cycle();
            chk("T3 wb_rd", 32'(wb_rd), 32'(exp_rd));
            ard[t % 2]  = ard[t % 2] + 5'd1;
            adat[t % 2] = $urandom;
        end
        chk("T3 conflict_cnt", 32'(conflict_cnt), 32'd0);
        av[0] = 1'b0;
        av[1] = 1'b0;

        // T1: pipe only.
        pipe_regwrite = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEAD_BEEF;
        pack();
        #1;
        chk("T1 aux_ready", 32'(aux_ready), 32'd0);
        cycle();
        chk("T1 wb_regwrite", 32'(wb_regwrite), 32'd1);
        chk("T1 wb_rd", 32'(wb_rd), 32'd5);
        chk("T1 wb_write_data", wb_write_data, 32'hDEAD_BEEF);

        // T2: pipe and aux0 collide; pipe first, aux0 next cycle.
        pipe_rd = 5'd7; pipe_data = 32'h7777_0007;
        av[0] = 1'b1; ard[0] = 5'd9; adat[0] = 32'h9999_0009;
        pack();
        #1;
        chk("T2 c1 aux_ready", 32'(aux_ready), 32'd0);
        chk("T2 c1 mask9", 32'(aux_pending_mask[9]), 32'd1);
        cycle();
        chk("T2 c1 wb_rd", 32'(wb_rd), 32'd7);
        pipe_regwrite = 1'b0;
        pack();
        #1;
        chk("T2 c2 aux_ready", 32'(aux_ready), 32'd1);
        chk("T2 c2 mask9", 32'(aux_pending_mask[9]), 32'd1);
        cycle();
        chk("T2 c2 wb_rd", 32'(wb_rd), 32'd9);
        chk("T2 c2 wb_write_data", wb_write_data, 32'h9999_0009);
        av[0] = 1'b0;

        // T4: pipe to x0 is idle; aux1 wins, then an aux1 write to x0 is swallowed.
        pipe_regwrite = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h1234_5678;
        av[1] = 1'b1; ard[1] = 5'd3; adat[1] = 32'h0000_0333;
        pack();
        #1;
        chk("T4 aux_ready", 32'(aux_ready), 32'd2);
        cycle();
        chk("T4 wb_rd", 32'(wb_rd), 32'd3);
        ard[1] = 5'd0; adat[1] = 32'h0BAD_0000;
        pack();
        #1;
        chk("T4 x0 aux_ready", 32'(aux_ready), 32'd2);
        cycle();
        chk("T4 x0 wb_regwrite", 32'(wb_regwrite), 32'd0);
        av[1] = 1'b0;
        pipe_regwrite = 1'b0;

        // Random traffic with a dense pipeline.
        for (int n = 0; n < 400; n++) begin
            pipe_regwrite = ($urandom_range(0, 3) != 0);
            pipe_rd       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pipe_data     = $urandom;
            cycle();
            if (g_last >= 0) new_req(g_last);
            for (int i = 0; i < N_AUX; i++)
                if (!av[i] && $urandom_range(0, 1) == 1) new_req(i);
        end

        // Drain outstanding aux requests with the pipe idle.
        pipe_regwrite = 1'b0;
        for (int n = 0; n < 4 * N_AUX; n++) begin
            cycle();
            if (g_last >= 0) av[g_last] = 1'b0;
        end

        // T6: asynchronous reset in the middle of a transfer, pointer at 1.
        av[0] = 1'b1; ard[0] = 5'd10; adat[0] = 32'hA0A0_000A;
        cycle();
        chk("T6 pre grant", 32'(g_last), 32'd0);
        av[0] = 1'b1; ard[0] = 5'd11; adat[0] = 32'hB1B1_000B;
        av[1] = 1'b1; ard[1] = 5'd13; adat[1] = 32'hD3D3_000D;
        pack();
        #2;
        reset = 1'b1;
        #1;
        chk("T6 wb_regwrite", 32'(wb_regwrite), 32'd0);
        chk("T6 wb_rd", 32'(wb_rd), 32'd0);
        chk("T6 wb_write_data", wb_write_data, 32'd0);
        chk("T6 conflict_cnt", 32'(conflict_cnt), 32'd0);
        chk("T6 aux_ready", 32'(aux_ready), 32'd0);
        chk("T6 pipe_stall", 32'(pipe_stall), 32'd0);
        chk("T6 mask", aux_pending_mask, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("T6 first grant", 32'(aux_ready), 32'd1);
        cycle();
        chk("T6 wb_rd", 32'(wb_rd), 32'd11);
        av[0] = 1'b0;
        cycle();
        av[1] = 1'b0;
        cycle();

        // T5: continuous pipe writes with aux0 waiting.
        av[0] = 1'b1; ard[0] = 5'd12; adat[0] = 32'hC0C0_000C;
        pipe_regwrite = 1'b1;
`ifdef STARVE_GUARD_EN
        for (int k = 0; k <= MAX_WAIT + 1; k++) begin
            pipe_rd   = 5'($urandom_range(1, 31));
            pipe_data = $urandom;
            pack();
            #1;
            chk("T5 aux_ready", 32'(aux_ready), (k == MAX_WAIT) ? 32'd1 : 32'd0);
            chk("T5 pipe_stall", 32'(pipe_stall), (k == MAX_WAIT) ? 32'd1 : 32'd0);
            cycle();
            if (g_last == 0) av[0] = 1'b0;
        end
        chk("T5 starved wb_rd", 32'(wb_rd), 32'(pipe_rd));
`else
        for (int k = 0; k < CMAX + 5; k++) begin
            pipe_rd   = 5'($urandom_range(1, 31));
            pipe_data = $urandom;
            cycle();
        end
        chk("T5 aux_ready", 32'(aux_ready), 32'd0);
        chk("T5 saturated cnt", 32'(conflict_cnt), 32'h0000_FFFF);
`endif
        pipe_regwrite = 1'b0;
        av[0] = 1'b0;
        pack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
